// File: rtl/splat_vec_pipe.sv
// -----------------------------------------------------------------------------
// splat_vec_pipe
//
// Two-stage pipelined element splat. This block picks one byte, half or word
// out of a DW-bit scalar and replicates it across a VW-bit vector. The vector
// is returned as two halves, vy_hi and vy_lo, for the HI/LO writeback path.
// Both sides use valid/ready handshakes, and the pipe sustains one operation
// per cycle.
//
// Parameters
//   DW  scalar source width (power of 2, >= 32)
//   VW  vector result width (integer multiple of DW, even)
//   SW  element-select width, derived as $clog2(DW/8) (not overridable)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   source operand valid
//   in_ready   unit can accept an operand this cycle
//   s          scalar source
//   esz        element size: 00 byte, 01 half, 10 word, 11 illegal
//   sel        element index, 0 = most-significant element
//   zhi        (only with SPLAT_ZHI_EN) zero the HI half and fill only the LO half
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   vy_hi      upper half of the replicated vector
//   vy_lo      lower half of the replicated vector
//   err        result came from an illegal esz (qualified by out_valid)
//
// Optional feature macro: SPLAT_ZHI_EN
//   When it is defined, the zhi input exists. When it is undefined, the block
//   always does a full fill.
// -----------------------------------------------------------------------------
module splat_vec_pipe #(
    parameter int DW = 32,
    parameter int VW = 64,
    localparam int SW = $clog2(DW / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     s,
    input  logic [1:0]        esz,
    input  logic [SW-1:0]     sel,
`ifdef SPLAT_ZHI_EN
    input  logic              zhi,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VW/2-1:0]   vy_hi,
    output logic [VW/2-1:0]   vy_lo,
    output logic              err
);

    localparam int NB = DW / 8;
    localparam int NH = DW / 16;
    localparam int NW = DW / 32;

    // ------------------------------------------------------------------
    // Handshake / stall control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_en;
    logic s2_en;

    // S2 can load when it is empty or is being drained this cycle.
    // S1 can load when it is empty or can push forward into S2.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    logic zhi_in;
`ifdef SPLAT_ZHI_EN
    assign zhi_in = zhi;
`else
    assign zhi_in = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic [DW-1:0] s1_s;
    logic [1:0]    s1_esz;
    logic [SW-1:0] s1_sel;
    logic          s1_zhi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_s     <= '0;
            s1_esz   <= '0;
            s1_sel   <= '0;
            s1_zhi   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_s   <= s;
                s1_esz <= esz;
                s1_sel <= sel;
                s1_zhi <= zhi_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Element extraction
    // ------------------------------------------------------------------
    // Element k sits at bit offset (count-1-k)*EW from the LSB, because
    // sel = 0 picks the most-significant element. For half and word, the
    // upper select bits are masked off, which gives sel mod count.
    logic [SW-1:0] bidx;
    logic [SW-1:0] hidx;
    logic [SW-1:0] widx;
    logic [SW+2:0] b_amt;
    logic [SW+3:0] h_amt;
    logic [SW+4:0] w_amt;
    logic [7:0]    b_elem;
    logic [15:0]   h_elem;
    logic [31:0]   w_elem;

    assign bidx   = s1_sel;
    assign hidx   = s1_sel & SW'(NH - 1);
    assign widx   = s1_sel & SW'(NW - 1);
    assign b_amt  = {SW'(NB - 1) - bidx, 3'b000};
    assign h_amt  = {SW'(NH - 1) - hidx, 4'b0000};
    assign w_amt  = {SW'(NW - 1) - widx, 5'b00000};
    assign b_elem = 8'(s1_s >> b_amt);
    assign h_elem = 16'(s1_s >> h_amt);
    assign w_elem = 32'(s1_s >> w_amt);

    // ------------------------------------------------------------------
    // Replication across the full vector for each element size
    // ------------------------------------------------------------------
    logic [VW-1:0] fill_b;
    logic [VW-1:0] fill_h;
    logic [VW-1:0] fill_w;

    generate
        for (genvar gi = 0; gi < VW / 8; gi++) begin : g_fill_b
            assign fill_b[gi*8 +: 8] = b_elem;
        end
        for (genvar gi = 0; gi < VW / 16; gi++) begin : g_fill_h
            assign fill_h[gi*16 +: 16] = h_elem;
        end
        for (genvar gi = 0; gi < VW / 32; gi++) begin : g_fill_w
            assign fill_w[gi*32 +: 32] = w_elem;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [VW-1:0]   res_full;
    logic [VW/2-1:0] res_hi;
    logic [VW/2-1:0] res_lo;
    logic            res_err;

    always_comb begin
        res_full = '0;
        res_err  = 1'b0;
        case (s1_esz)
            2'b00:   res_full = fill_b;
            2'b01:   res_full = fill_h;
            2'b10:   res_full = fill_w;
            default: res_err  = 1'b1;
        endcase
        res_hi = res_full[VW-1:VW/2];
        res_lo = res_full[VW/2-1:0];
        // Legacy HI-zeroed splat: the LO half is already the replicated
        // pattern, so only the HI half has to be cleared.
        if (s1_zhi) begin
            res_hi = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers. Data holds on bubbles and during a stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            vy_hi     <= '0;
            vy_lo     <= '0;
            err       <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                vy_hi <= res_hi;
                vy_lo <= res_lo;
                err   <= res_err;
            end
        end
    end

endmodule
